// File: rtl/uart_cmd_responder.sv
// Host command responder: parses 'W'/'R' frames from the UART byte stream,
// runs one 32-bit memory-bus transaction per frame and returns the response bytes.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 52080
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        rx_drop,
  output logic        frame_abort
);

  localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     OP_WRITE = 8'h57;
  localparam logic [7:0]     OP_READ  = 8'h52;
  localparam logic [7:0]     RESP_ACK = 8'h4B;
  localparam logic [7:0]     RESP_UNK = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_TX_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   shift_q, shift_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          multi_q, multi_d;
  logic          first_q, first_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      tx_data_q <= '0;
      multi_q   <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
      multi_q   <= multi_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    tx_data_d   = tx_data_q;
    multi_d     = multi_q;
    first_d     = 1'b0;
    rx_drop     = 1'b0;
    frame_abort = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          cnt_d = '0;
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            we_d    = (rx_data == OP_WRITE);
            state_d = S_ADDR;
          end else begin
            tx_data_d = RESP_UNK;
            multi_d   = 1'b0;
            state_d   = S_RESP;
          end
        end
      end

      S_ADDR, S_DATA: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (rx_ready) begin
          if (state_q == S_ADDR) begin
            addr_d = {rx_data, addr_q[31:8]};
          end else begin
            wdata_d = {rx_data, wdata_q[31:8]};
          end
          if (cnt_q == 3'd3) begin
            cnt_d   = '0;
            state_d = (state_q == S_ADDR && we_q) ? S_DATA : S_BUS;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (tmo_q == TMO_MAX) begin
          frame_abort = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_BUS: begin
        if (mem_ack) begin
          cnt_d     = '0;
          multi_d   = !we_q;
          tx_data_d = we_q ? RESP_ACK : mem_rdata[7:0];
          shift_d   = {8'h00, mem_rdata[31:8]};
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        cnt_d   = cnt_q + 3'd1;
        first_d = 1'b1;
        state_d = S_TX_WAIT;
      end

      S_TX_WAIT: begin
        // tx_busy only becomes meaningful one cycle after the request.
        if (!first_q && !tx_busy) begin
          if (multi_q && cnt_q != 3'd4) begin
            tx_data_d = shift_q[7:0];
            shift_d   = {8'h00, shift_q[31:8]};
            state_d   = S_RESP;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (rx_ready && (state_q == S_BUS || state_q == S_RESP || state_q == S_TX_WAIT)) begin
      rx_drop = 1'b1;
    end
  end

  assign mem_req   = (state_q == S_BUS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign tx_req    = (state_q == S_RESP);
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized bench for uart_cmd_responder: drives frames byte by byte, models the
// UART transmitter and a bus slave, and checks responses against a frame-level model.
module tb_uart_cmd_responder;

  localparam int TMO = 100;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        rx_drop;
  logic        frame_abort;

  int n_checks = 0;
  int n_errors = 0;
  int drop_cnt = 0;
  int abort_cnt = 0;
  int slave_wait = -1;

  logic [7:0]  got_q[$];
  bus_t        bus_log[$];
  logic [7:0]  last_tx = 8'h00;
  logic        prev_req = 1'b0;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] addr_pool[4] = '{32'h1A00_0010, 32'h0000_0100, 32'h0000_0000, 32'h1C00_8004};

  uart_cmd_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .tx_busy    (tx_busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .rx_drop    (rx_drop),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Transmitter model: busy rises the cycle after tx_req and stays for 1..4 more cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_req === 1'b1) begin
        got_q.push_back(tx_data);
        last_tx = tx_data;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Transmit handshake rules and pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req === 1'b1) begin
        chk("tx_req_while_busy", 32'(tx_busy), 32'd0);
        chk("tx_req_back_to_back", 32'(prev_req), 32'd0);
      end
      if (tx_busy === 1'b1) chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
      prev_req = tx_req;
      if (rx_drop === 1'b1) drop_cnt++;
      if (frame_abort === 1'b1) abort_cnt++;
    end
  end

  // Bus slave with configurable or random wait states; tolerates abandoned requests.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        automatic bus_t t = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        automatic int w = (slave_wait >= 0) ? slave_wait : int'($urandom_range(0, 3));
        automatic bit gone = 1'b0;
        bus_log.push_back(t);
        for (int i = 0; i < w; i++) begin
          @(negedge clk);
          if (mem_req !== 1'b1) begin
            gone = 1'b1;
            break;
          end
          chk("bus_we_stable", 32'(mem_we), 32'(t.we));
          chk("bus_addr_stable", mem_addr, t.addr);
          chk("bus_wdata_stable", mem_wdata, t.wdata);
        end
        if (!gone) begin
          mem_rdata = t.we ? $urandom : (slave_mem.exists(t.addr) ? slave_mem[t.addr] : dflt(t.addr));
          if (t.we) slave_mem[t.addr] = t.wdata;
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          chk("req_drop_after_ack", 32'(mem_req), 32'd0);
          chk("resp_after_ack", 32'(tx_req), 32'd1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame and checks it against the frame-level model.
  task automatic run_frame(input logic [7:0] fb[$], input int gap_max, input bit inject,
                           input int stall1);
    automatic logic [7:0]  op = fb[0];
    automatic logic [7:0]  exp_resp[$];
    automatic bit          exp_bus = (op == 8'h57 || op == 8'h52);
    automatic logic [31:0] a = 32'h0;
    automatic logic [31:0] d = 32'h0;
    automatic int          d0 = drop_cnt;
    automatic int          a0 = abort_cnt;
    if (exp_bus) a = {fb[4], fb[3], fb[2], fb[1]};
    if (op == 8'h57) begin
      d = {fb[8], fb[7], fb[6], fb[5]};
      exp_resp.push_back(8'h4B);
    end else if (op == 8'h52) begin
      automatic logic [31:0] v = ref_read(a);
      for (int i = 0; i < 4; i++) exp_resp.push_back(v[8*i +: 8]);
    end else begin
      exp_resp.push_back(8'h3F);
    end

    @(posedge clk);
    #1;
    got_q.delete();
    bus_log.delete();
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i]);
      if (i == 1 && stall1 > 0) idle(stall1);
      else if (i != fb.size() - 1) idle($urandom_range(0, gap_max));
    end
    @(negedge clk);
    if (exp_bus) begin
      chk("req_latency", 32'(mem_req), 32'd1);
    end else begin
      chk("unk_latency", 32'(tx_req), 32'd1);
      chk("unk_byte", 32'(tx_data), 32'h3F);
      chk("unk_no_req", 32'(mem_req), 32'd0);
    end

    if (inject) begin
      for (int c = 0; c < 200 && got_q.size() == 0; c++) @(negedge clk);
      @(posedge clk);
      #1 send_byte(8'h52);
    end

    for (int c = 0; c < 3000; c++) begin
      if (got_q.size() >= exp_resp.size() && busy === 1'b0) break;
      @(negedge clk);
    end
    chk("busy_fall", 32'(busy), 32'd0);
    chk("tx_idle_at_done", 32'(tx_busy), 32'd0);
    chk("resp_len", 32'(got_q.size()), 32'(exp_resp.size()));
    for (int i = 0; i < exp_resp.size() && i < got_q.size(); i++)
      chk($sformatf("resp_byte%0d", i), 32'(got_q[i]), 32'(exp_resp[i]));
    chk("bus_count", 32'(bus_log.size()), exp_bus ? 32'd1 : 32'd0);
    if (exp_bus && bus_log.size() > 0) begin
      chk("bus_we", 32'(bus_log[0].we), 32'(op == 8'h57));
      chk("bus_addr", bus_log[0].addr, a);
      if (op == 8'h57) chk("bus_wdata", bus_log[0].wdata, d);
    end
    chk("drop_pulses", 32'(drop_cnt - d0), inject ? 32'd1 : 32'd0);
    chk("abort_pulses", 32'(abort_cnt - a0), 32'd0);
    if (op == 8'h57) ref_mem[a] = d;
    $display("frame op=%h addr=%h wdata=%h resp_bytes=%0d drops=%0d", op, a, d,
             got_q.size(), drop_cnt - d0);
  endtask

  initial begin
    automatic logic [7:0] fb[$];
    rstn     = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({rx_drop, frame_abort}), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    fb = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h1A, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(fb, 3, 1'b0, 0);

    ref_mem[32'h100] = 32'h1234_5678;
    slave_mem[32'h100] = 32'h1234_5678;
    slave_wait = 3;
    fb = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
    run_frame(fb, 2, 1'b0, 0);
    slave_wait = 0;
    fb = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h1A};
    run_frame(fb, 2, 1'b0, 0);
    slave_wait = -1;

    fb = '{8'hA5};
    run_frame(fb, 0, 1'b0, 0);

    // Partial frame abandoned after TMO idle cycles.
    begin
      automatic int at = -1;
      automatic int a0 = abort_cnt;
      bus_log.delete();
      @(posedge clk);
      #1 send_byte(8'h57);
      send_byte(8'h10);
      for (int c = 1; c <= TMO + 10; c++) begin
        @(negedge clk);
        if (frame_abort === 1'b1) begin
          at = c;
          break;
        end
      end
      chk("abort_cycle", 32'(at), 32'(TMO + 1));
      repeat (3) @(negedge clk);
      chk("abort_once", 32'(abort_cnt - a0), 32'd1);
      chk("abort_no_req", 32'(bus_log.size()), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      $display("timeout abort after %0d idle cycles", at);
    end
    fb = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 2, 1'b0, 0);

    // Byte arriving exactly on the expiry cycle is accepted.
    fb = '{8'h57, 8'h04, 8'h80, 8'h00, 8'h1C, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(fb, 1, 1'b0, TMO);

    fb = '{8'h52, 8'h04, 8'h80, 8'h00, 8'h1C};
    run_frame(fb, 1, 1'b1, 0);

    // Reset during an outstanding bus request.
    slave_wait = 40;
    @(posedge clk);
    #1;
    fb = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h99, 8'h88, 8'h77, 8'h66};
    foreach (fb[i]) send_byte(fb[i]);
    for (int c = 0; c < 20 && mem_req !== 1'b1; c++) @(negedge clk);
    chk("mid_req_seen", 32'(mem_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_tx_req", 32'(tx_req), 32'd0);
    $display("reset asserted mid-request");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    slave_wait = -1;
    repeat (3) @(negedge clk);
    fb = '{8'h57, 8'h08, 8'h00, 8'h00, 8'h1A, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(fb, 2, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      automatic int          k = $urandom_range(0, 2);
      automatic logic [31:0] a = addr_pool[$urandom_range(0, 3)];
      automatic logic [31:0] d = $urandom;
      automatic logic [7:0]  op;
      fb.delete();
      if (k == 0) op = 8'h57;
      else if (k == 1) op = 8'h52;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
      end
      fb.push_back(op);
      if (k != 2) for (int i = 0; i < 4; i++) fb.push_back(a[8*i +: 8]);
      if (k == 0) for (int i = 0; i < 4; i++) fb.push_back(d[8*i +: 8]);
      run_frame(fb, 4, 1'($urandom_range(0, 3) == 0) && k == 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
